seg7_disp_ctrl: RTL and testbench

Downstream consumer of the LM07 SPI reader's display strobes (disp[1:0]) and segment bus (dataSeg[7:0]). It captures the MSB and LSB segment patterns into a double buffer and commits them atomically. It then drives a time-multiplexed 2-digit 7-segment display with anti-ghost blanking and 4-level brightness. A watchdog shows dashes when the sensor path stops updating.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_mux_timer.sv | 38 +++
 rtl/seg7_disp_ctrl.sv | 128 ++++++++++++
 tb/tb_seg7_disp_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 2-digit 7-segment display controller.
package seg7_pkg;

  // Digit strobe codes driven by the SPI reader.
  typedef enum logic [1:0] {
    DISP_IDLE = 2'b00,
    DISP_LSB  = 2'b01,
    DISP_MSB  = 2'b10,
    DISP_ILL  = 2'b11
  } disp_e;

  // Segment bit positions within the 8-bit segment bus (a is the MSB).
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  // Dash: only the middle segment is lit.
  localparam logic [7:0] SEG_DASH  = 8'(1 << SEG_G);

endpackage

// File: rtl/seg7_mux_timer.sv
// Refresh timing: slot counter, digit select, frame tick and lit-window decode.
module seg7_mux_timer #(
  parameter int REFRESH_LOG2 = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] bright_i,
  output logic       sel_msb_o,
  output logic       frame_tick_o,
  output logic       lit_o
);

  logic [REFRESH_LOG2-1:0] sc_q;
  logic                    sel_q;
  logic                    wrap;

  assign wrap = &sc_q;

  // Free-running slot counter; the digit select flips at every slot boundary.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sc_q  <= '0;
      sel_q <= 1'b1;
    end else begin
      sc_q <= sc_q + REFRESH_LOG2'(1);
      if (wrap) sel_q <= ~sel_q;
    end
  end

  assign sel_msb_o    = sel_q;
  // A frame ends when the LSB slot wraps.
  assign frame_tick_o = wrap & ~sel_q;
  // Blank lead-in hides ghosting; the top two counter bits set the duty quarter.
  assign lit_o        = (sc_q >= REFRESH_LOG2'(BLANK_CYCLES)) &&
                        (sc_q[REFRESH_LOG2-1 -: 2] <= bright_i);

endmodule

// File: rtl/seg7_disp_ctrl.sv
// Double-buffered capture of reader segment data and multiplexed 2-digit drive.
module seg7_disp_ctrl #(
  parameter int REFRESH_LOG2 = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int STALE_FRAMES = 8
) (
  input  logic       SYSCLK,
  input  logic       RSTN,
  input  logic [1:0] disp,
  input  logic [7:0] seg_in,
  input  logic [1:0] bright,
  output logic [7:0] seg_out,
  output logic [1:0] an,
  output logic       stale,
  output logic       err,
  output logic       upd
);
  import seg7_pkg::*;

  localparam int             WDW    = $clog2(STALE_FRAMES + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(STALE_FRAMES);

  logic           disp0_q;
  logic [7:0]     sh_msb_q, sh_msb_d, sh_lsb_q, sh_lsb_d;
  logic [7:0]     dmsb_q, dmsb_d, dlsb_q, dlsb_d;
  logic           seen_q, seen_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           stale_q, stale_d, err_q, err_d, upd_q, upd_d;
  logic [7:0]     seg_q, seg_d;
  logic [1:0]     an_q, an_d;
  logic           sel_msb, frame_tick, lit, commit;

  seg7_mux_timer #(
    .REFRESH_LOG2(REFRESH_LOG2),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk_i       (SYSCLK),
    .rst_ni      (RSTN),
    .bright_i    (bright),
    .sel_msb_o   (sel_msb),
    .frame_tick_o(frame_tick),
    .lit_o       (lit)
  );

  // Commit on the falling edge of the LSB strobe, only after an MSB write.
  assign commit = disp0_q & ~disp[0] & seen_q;

  // Next state for capture, commit, watchdog and the registered display drive.
  always_comb begin
    sh_msb_d = sh_msb_q;
    sh_lsb_d = sh_lsb_q;
    dmsb_d   = dmsb_q;
    dlsb_d   = dlsb_q;
    seen_d   = seen_q;
    wd_d     = wd_q;
    stale_d  = stale_q;
    err_d    = err_q;
    upd_d    = commit;
    seg_d    = SEG_BLANK;
    an_d     = 2'b00;

    // Commit beats a coincident frame tick so fresh data never shows as stale.
    if (commit) begin
      dmsb_d  = sh_msb_q;
      dlsb_d  = sh_lsb_q;
      seen_d  = 1'b0;
      wd_d    = '0;
      stale_d = 1'b0;
    end else if (frame_tick) begin
      if (wd_q != WD_MAX) wd_d = wd_q + WDW'(1);
      if (wd_q >= WD_MAX - WDW'(1)) stale_d = 1'b1;
    end

    // Capture after commit so an MSB write in the commit cycle opens a new pair.
    case (disp_e'(disp))
      DISP_MSB: begin
        sh_msb_d = seg_in;
        seen_d   = 1'b1;
      end
      DISP_LSB:  sh_lsb_d = seg_in;
      DISP_ILL:  err_d    = 1'b1;
      default: ;
    endcase

    if (lit) begin
      an_d  = sel_msb ? 2'b10 : 2'b01;
      seg_d = stale_q ? SEG_DASH : (sel_msb ? dmsb_q : dlsb_q);
    end
  end

  // State and output registers.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      disp0_q  <= 1'b0;
      sh_msb_q <= 8'h00;
      sh_lsb_q <= 8'h00;
      dmsb_q   <= 8'h00;
      dlsb_q   <= 8'h00;
      seen_q   <= 1'b0;
      wd_q     <= '0;
      stale_q  <= 1'b1;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= 2'b00;
    end else begin
      disp0_q  <= disp[0];
      sh_msb_q <= sh_msb_d;
      sh_lsb_q <= sh_lsb_d;
      dmsb_q   <= dmsb_d;
      dlsb_q   <= dlsb_d;
      seen_q   <= seen_d;
      wd_q     <= wd_d;
      stale_q  <= stale_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign an      = an_q;
  assign stale   = stale_q;
  assign err     = err_q;
  assign upd     = upd_q;

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Self-checking bench for seg7_disp_ctrl: directed sequences, a lit-window
// vector table and randomized strobe traffic against a cycle reference model.
module tb_seg7_disp_ctrl;

  logic       SYSCLK = 1'b0;
  logic       RSTN   = 1'b0;
  logic [1:0] disp   = 2'b00;
  logic [7:0] seg_in = 8'h00;
  logic [1:0] bright = 2'b11;
  logic [7:0] seg_out;
  logic [1:0] an;
  logic       stale, err, upd;

  seg7_disp_ctrl dut (
    .SYSCLK (SYSCLK),
    .RSTN   (RSTN),
    .disp   (disp),
    .seg_in (seg_in),
    .bright (bright),
    .seg_out(seg_out),
    .an     (an),
    .stale  (stale),
    .err    (err),
    .upd    (upd)
  );

  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int errors = 0;

  // Reference model state; n counts clock edges since reset release.
  int         n;
  logic [7:0] m_shm, m_shl, m_dmsb, m_dlsb;
  logic       m_seen, m_prev0, m_err, m_stale;
  int         m_frames;

  // Observed display contents and pulse count.
  int         upd_cnt;
  logic [7:0] shown_msb, shown_lsb;

  typedef struct {
    logic [1:0] br;
    int         first;
    int         last;
  } win_t;
  win_t wt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; m_shm = 8'h00; m_shl = 8'h00; m_dmsb = 8'h00; m_dlsb = 8'h00;
    m_seen = 1'b0; m_prev0 = 1'b0; m_err = 1'b0; m_stale = 1'b1; m_frames = 0;
  endtask

  // Apply one cycle of inputs, predict the outputs after the edge, compare.
  task automatic step(input logic [1:0] d, input logic [7:0] s, input logic [1:0] b);
    int sc;
    bit smsb, lit, commit, frame;
    logic [1:0] e_an;
    logic [7:0] e_seg;
    logic e_stale, e_err, e_upd;
    disp = d; seg_in = s; bright = b;
    sc     = n % 16;
    smsb   = ((n / 16) % 2) == 0;
    lit    = (sc >= 2) && ((sc / 4) <= int'(b));
    e_an   = lit ? (smsb ? 2'b10 : 2'b01) : 2'b00;
    e_seg  = !lit ? 8'h00 : (m_stale ? 8'h02 : (smsb ? m_dmsb : m_dlsb));
    frame  = (n % 32) == 31;
    commit = m_prev0 && !d[0] && m_seen;
    e_upd  = commit;
    e_err  = m_err || (d == 2'b11);
    e_stale = m_stale;
    if (commit) begin
      m_dmsb = m_shm; m_dlsb = m_shl; m_frames = 0; e_stale = 1'b0; m_seen = 1'b0;
    end else if (frame) begin
      if (m_frames < 8) m_frames++;
      if (m_frames >= 8) e_stale = 1'b1;
    end
    if (d == 2'b10) begin m_shm = s; m_seen = 1'b1; end
    if (d == 2'b01) m_shl = s;
    m_prev0 = d[0]; m_err = e_err; m_stale = e_stale;
    @(posedge SYSCLK); #1;
    n++;
    chk("outs{an,seg,stale,err,upd}", {19'd0, an, seg_out, stale, err, upd},
        {19'd0, e_an, e_seg, e_stale, e_err, e_upd});
    if (upd) upd_cnt++;
    if (an == 2'b10) shown_msb = seg_out;
    if (an == 2'b01) shown_lsb = seg_out;
  endtask

  task automatic idle(input int cyc, input logic [1:0] b);
    for (int i = 0; i < cyc; i++) step(2'b00, 8'h00, b);
  endtask

  task automatic pair(input logic [7:0] msb, input logic [7:0] lsb);
    step(2'b10, msb, 2'b11); step(2'b10, msb, 2'b11); step(2'b00, 8'h00, 2'b11);
    step(2'b01, lsb, 2'b11); step(2'b01, lsb, 2'b11); step(2'b00, 8'h00, 2'b11);
  endtask

  initial begin
    int u0, g;
    logic [7:0] rm, rl;
    logic [1:0] rb;
    wt[0] = '{2'd0, 2, 3};
    wt[1] = '{2'd1, 2, 7};
    wt[2] = '{2'd2, 2, 11};
    wt[3] = '{2'd3, 2, 15};
    upd_cnt = 0; shown_msb = 8'h00; shown_lsb = 8'h00;
    model_reset();

    // Reset state.
    #8;
    chk("reset_outs", {an, seg_out, stale, err, upd}, {2'b00, 8'h00, 1'b1, 1'b0, 1'b0});
    #14 RSTN = 1'b1;

    // 1: dashes on both digits before any commit.
    idle(64, 2'b11);
    chk("t1_stale", stale, 1);
    chk("t1_msb_dash", shown_msb, 8'h02);
    chk("t1_lsb_dash", shown_lsb, 8'h02);

    // 2: first complete pair.
    u0 = upd_cnt;
    pair(8'h60, 8'hFC);
    idle(40, 2'b11);
    chk("t2_upd_once", upd_cnt - u0, 1);
    chk("t2_stale", stale, 0);
    chk("t2_msb", shown_msb, 8'h60);
    chk("t2_lsb", shown_lsb, 8'h FC);

    // 3: LSB strobe alone does not commit.
    u0 = upd_cnt;
    step(2'b01, 8'hDA, 2'b11); idle(40, 2'b11);
    chk("t3_no_upd", upd_cnt - u0, 0);
    chk("t3_msb_kept", shown_msb, 8'h60);
    chk("t3_lsb_kept", shown_lsb, 8'hFC);
    pair(8'h9E, 8'hDA);
    idle(40, 2'b11);
    chk("t3_msb_new", shown_msb, 8'h9E);
    chk("t3_lsb_new", shown_lsb, 8'hDA);

    // 4: commit landing on the 8th frame tick keeps stale low.
    g = 0;
    while (!(m_frames == 7 && (n % 32) == 28) && g < 2000) begin
      step(2'b00, 8'h00, 2'b11); g++;
    end
    chk("t4_align_in_time", g < 2000, 1);
    chk("t4_pre_stale", stale, 0);
    u0 = upd_cnt;
    step(2'b10, 8'h0C, 2'b11); step(2'b00, 8'h00, 2'b11);
    step(2'b01, 8'hB6, 2'b11); step(2'b00, 8'h00, 2'b11);
    chk("t4_tick_commit_upd", upd_cnt - u0, 1);
    chk("t4_tick_commit_stale", stale, 0);
    idle(250, 2'b11);
    chk("t4_not_yet_stale", stale, 0);
    idle(40, 2'b11);
    chk("t4_stale", stale, 1);
    chk("t4_dash", shown_msb, 8'h02);

    // 5: lit window per brightness level from the vector table.
    pair(8'hF2, 8'h66);
    for (int t = 0; t < 4; t++) begin
      while ((n % 16) != 0) step(2'b00, 8'h00, wt[t].br);
      for (int k = 0; k < 32; k++) begin
        int sc;
        sc = n % 16;
        step(2'b00, 8'h00, wt[t].br);
        chk($sformatf("t5_lit_b%0d_sc%0d", wt[t].br, sc), an != 2'b00,
            (sc >= wt[t].first) && (sc <= wt[t].last));
      end
    end

    // 6: illegal code is sticky; reset clears it asynchronously.
    step(2'b11, 8'hFF, 2'b11);
    chk("t6_err", err, 1);
    idle(20, 2'b11);
    chk("t6_err_sticky", err, 1);
    while ((n % 16) != 8) step(2'b00, 8'h00, 2'b11);
    RSTN = 1'b0;
    #2;
    chk("t6_async_reset", {an, seg_out, stale, err, upd}, {2'b00, 8'h00, 1'b1, 1'b0, 1'b0});
    #10 RSTN = 1'b1;
    model_reset();
    idle(40, 2'b11);
    chk("t6_dash_after_reset", shown_msb, 8'h02);

    // Randomized strobe traffic against the model.
    for (int r = 0; r < 80; r++) begin
      rb = 2'($urandom_range(0, 3));
      rm = 8'($urandom); rl = 8'($urandom);
      case ($urandom_range(0, 7))
        0: step(2'b01, rl, rb);
        1: step(2'b10, rm, rb);
        2: idle(300, rb);
        default: begin
          for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(2'b10, rm, rb);
          idle($urandom_range(1, 3), rb);
          for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(2'b01, rl, rb);
        end
      endcase
      idle($urandom_range(1, 40), rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
